dff_response_checker: RTL and testbench
=======================================

DFF_RESPONSE_CHECKER -- requirements
Module: dff_response_checker

Interface
REQ-001 Parameter CNT_W, default 16: width of the sample and error counters.
REQ-002 Parameter RUN_LEN, default 8: number of checked samples per run; legal range 1 to 2^CNT_W-1.
REQ-003 Parameter SETTLE, default 1: idle cycles after start before checking begins; legal range 0 to 15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 start  input  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
REQ-007 dut_rst  input  1  observed flip-flop reset; active-high, as driven to the flip-flop.
REQ-008 d_obs  input  1  observed flip-flop D input.
REQ-009 q_obs  input  1  observed flip-flop Q output.
REQ-010 busy  output  1  high in SETTLE and CHECK.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  high in DONE when err_cnt equals 0.
REQ-013 sample_cnt  output  CNT_W  samples checked in the current run.
REQ-014 err_cnt  output  CNT_W  mismatches in the current run; saturates at all-ones.

Function
REQ-015 The FSM SHALL have four states: IDLE, SETTLE, CHECK and DONE.
REQ-016 Transitions:
- IDLE -> SETTLE on start when SETTLE>0; IDLE -> CHECK on start when SETTLE=0.
- SETTLE -> CHECK after exactly SETTLE cycles.
- CHECK -> DONE on the cycle the RUN_LEN-th sample is counted.
- DONE -> SETTLE or CHECK on start, by the same rule as IDLE.
REQ-017 Every cycle, regardless of state, the block SHALL register exp_q: 0 if dut_rst=1, otherwise d_obs.
REQ-018 A one-bit exp_vld flag SHALL be set one cycle after the first registered exp_q and SHALL be cleared by rst.
REQ-019 In CHECK with exp_vld=1, each cycle SHALL:
- increment sample_cnt;
- compare q_obs with exp_q;
- increment err_cnt on mismatch.
REQ-020 The check latency SHALL be one cycle: the q_obs value at edge n is compared with the d_obs/dut_rst values sampled at edge n-1.
REQ-021 In CHECK with exp_vld=0, no sample SHALL be counted.
REQ-022 A start accepted in IDLE or DONE SHALL clear sample_cnt and err_cnt in the same edge.
REQ-023 A start asserted in SETTLE or CHECK SHALL be ignored.
REQ-024 err_cnt SHALL hold at all-ones once saturated; sample_cnt does not overflow because RUN_LEN is bounded.
REQ-025 pass SHALL be 0 outside DONE.
REQ-026 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 While rst=0 at a clock edge, the block SHALL enter IDLE and force the following to 0: busy, done, pass, sample_cnt, err_cnt, exp_q, exp_vld, and the settle counter.
REQ-028 A reset asserted mid-run SHALL abort the run; no done pulse is produced.

Configuration
REQ-029 Macro DFF_CHK_FIRST_ERR_EN, when defined, SHALL add these outputs:
- first_err_vld (1 bit);
- first_err_idx (CNT_W bits): the sample_cnt value of the first mismatch in the run;
- first_err_exp (1 bit): the expected value at that mismatch.
All three are cleared by reset and by an accepted start, and are written only on the first mismatch.
REQ-030 Without DFF_CHK_FIRST_ERR_EN, these ports and their registers SHALL not exist; all other behaviour is identical.

Structure
REQ-031 A shared package dff_chk_pkg SHALL hold:
- the state enum type chk_state_t (IDLE, SETTLE, CHECK, DONE);
- the default constants CHK_CNT_W_DEF, CHK_RUN_LEN_DEF and CHK_SETTLE_DEF.
REQ-032 A single sub-module sat_counter (width-parameterised, with clear, increment and saturate) SHALL implement both sample_cnt and err_cnt.

Verification
REQ-033 With defaults, hold rst=0 for 2 cycles, then start; drive q_obs equal to the previous d_obs for 12 cycles -> done after 1+8 cycles, sample_cnt=8, err_cnt=0, pass=1.
REQ-034 Inject q_obs inverted on checked samples 3 and 6 -> err_cnt=2, pass=0; with the macro defined, first_err_idx=3.
REQ-035 Set dut_rst=1 with d_obs=1 while q_obs=0, for 3 checked samples -> no errors; if q_obs=1 instead -> err_cnt=3.
REQ-036 Assert rst=0 during CHECK at sample 4 -> the next cycle shows IDLE, busy=0, done=0, both counters 0; a following start runs a clean full run.
REQ-037 Assert start in CHECK -> ignored, and sample_cnt continues uninterrupted; assert start in DONE -> counters clear and a new run begins.
REQ-038 With CNT_W=3, RUN_LEN=7 and all samples mismatched -> err_cnt=7 and holds; pass=0.

Source files
------------

// File: rtl/dff_chk_pkg.sv
// Shared types and default constants for the flip-flop response checker.
package dff_chk_pkg;

  // Checker run phases
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } chk_state_t;

  localparam int CHK_CNT_W_DEF   = 16;
  localparam int CHK_RUN_LEN_DEF = 8;
  localparam int CHK_SETTLE_DEF  = 1;

  // Load value for the settle down-counter; the last settle cycle is count 0.
  function automatic logic [3:0] settle_load(input int settle);
    settle_load = (settle > 0) ? 4'(settle - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/dff_response_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear wins over increment; increment stops at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dff_response_checker.sv
// Checks an observed D flip-flop (with active-high reset) against a
// one-cycle-delayed model of its D/reset inputs over a run of samples.
// Optional macro DFF_CHK_FIRST_ERR_EN adds first-mismatch capture outputs.
//
// state     | meaning
// ST_IDLE   | waiting for start after reset
// ST_SETTLE | waiting SETTLE cycles before checking
// ST_CHECK  | comparing q_obs to the registered expectation
// ST_DONE   | run finished, result on pass
module dff_response_checker
  import dff_chk_pkg::*;
#(
  parameter int CNT_W   = CHK_CNT_W_DEF,
  parameter int RUN_LEN = CHK_RUN_LEN_DEF,
  parameter int SETTLE  = CHK_SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_rst,
  input  logic             d_obs,
  input  logic             q_obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef DFF_CHK_FIRST_ERR_EN
  ,
  output logic             first_err_vld,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_exp
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(RUN_LEN - 1);
  localparam logic [3:0]       SETTLE_LOAD = settle_load(SETTLE);

  chk_state_t state;
  logic [3:0] settle_cnt;
  logic       exp_q;
  logic       exp_vld;
  logic       start_ok;
  logic       smp_inc;
  logic       mismatch;
  logic       err_inc;
  logic       last_smp;

  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign smp_inc  = (state == ST_CHECK) && exp_vld;
  assign mismatch = (q_obs != exp_q);
  assign err_inc  = smp_inc && mismatch;
  assign last_smp = smp_inc && (sample_cnt == LAST_IDX);

  // Model of the observed flop: Q one edge later is 0 under reset, else D.
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_q   <= 1'b0;
      exp_vld <= 1'b0;
    end else begin
      exp_q   <= dut_rst ? 1'b0 : d_obs;
      exp_vld <= 1'b1;
    end
  end

  // Run sequencing with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      settle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
            if (SETTLE > 0) begin
              state      <= ST_SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end else begin
              state <= ST_CHECK;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          if (last_smp) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // err_cnt has not yet absorbed this edge's sample
            pass  <= (err_cnt == '0) && !mismatch;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .inc (smp_inc),
    .cnt (sample_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .inc (err_inc),
    .cnt (err_cnt)
  );

`ifdef DFF_CHK_FIRST_ERR_EN
  // Capture the 1-based sample index and expected value of the first mismatch.
  always_ff @(posedge clk) begin
    if (!rst || start_ok) begin
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      first_err_exp <= 1'b0;
    end else if (err_inc && !first_err_vld) begin
      first_err_vld <= 1'b1;
      first_err_idx <= sample_cnt + CNT_W'(1);
      first_err_exp <= exp_q;
    end
  end
`endif

endmodule

// File: tb/tb_dff_response_checker.sv
// Directed bench for dff_response_checker: default instance plus a
// CNT_W=3 / RUN_LEN=7 instance sharing the same stimulus.
module tb_dff_response_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        dut_rst = 1'b0;
  logic        d_obs = 1'b0;
  logic        q_obs = 1'b0;
  logic        busy, done, pass;
  logic [15:0] sample_cnt, err_cnt;
  logic        s_busy, s_done, s_pass;
  logic [2:0]  s_sample_cnt, s_err_cnt;
`ifdef DFF_CHK_FIRST_ERR_EN
  logic        fe_vld, fe_exp, s_fe_vld, s_fe_exp;
  logic [15:0] fe_idx;
  logic [2:0]  s_fe_idx;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        exp_model = 1'b0;
  logic [15:0] pat = 16'hB2CE;

  always #5 clk = ~clk;

  dff_response_checker u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dut_rst    (dut_rst),
    .d_obs      (d_obs),
    .q_obs      (q_obs),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt)
`ifdef DFF_CHK_FIRST_ERR_EN
    ,
    .first_err_vld (fe_vld),
    .first_err_idx (fe_idx),
    .first_err_exp (fe_exp)
`endif
  );

  dff_response_checker #(.CNT_W(3), .RUN_LEN(7)) u_small (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dut_rst    (dut_rst),
    .d_obs      (d_obs),
    .q_obs      (q_obs),
    .busy       (s_busy),
    .done       (s_done),
    .pass       (s_pass),
    .sample_cnt (s_sample_cnt),
    .err_cnt    (s_err_cnt)
`ifdef DFF_CHK_FIRST_ERR_EN
    ,
    .first_err_vld (s_fe_vld),
    .first_err_idx (s_fe_idx),
    .first_err_exp (s_fe_exp)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, q_obs = model of the observed flop (optionally flipped).
  task automatic step(input logic d, input logic r, input logic flip, input logic st);
    dut_rst = r;
    d_obs   = d;
    q_obs   = exp_model ^ flip;
    start   = st;
    @(posedge clk);
    #1;
    exp_model = r ? 1'b0 : d;
    start     = 1'b0;
  endtask

  task automatic run_start();
    step(pat[0], 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_steps(input int k0, input int k1,
                           input logic [15:0] flip_m, input logic [15:0] rst_m);
    for (int k = k0; k <= k1; k++) begin
      step(pat[k], rst_m[k], flip_m[k], 1'b0);
    end
  endtask

  initial begin
    // Reset for two cycles
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_sample", sample_cnt, 16'd0);
    chk("rst_err", err_cnt, 16'd0);
    rst = 1'b1;

    // Clean run: done 1+8 cycles after start
    run_start();
    chk("clean_busy_settle", busy, 1'b1);
    chk("clean_done_settle", done, 1'b0);
    run_steps(1, 8, 16'h0000, 16'h0000);
    chk("clean_sample_k8", sample_cnt, 16'd7);
    chk("clean_done_k8", done, 1'b0);
    chk("clean_pass_k8", pass, 1'b0);
    run_steps(9, 9, 16'h0000, 16'h0000);
    chk("clean_done", done, 1'b1);
    chk("clean_busy", busy, 1'b0);
    chk("clean_sample", sample_cnt, 16'd8);
    chk("clean_err", err_cnt, 16'd0);
    chk("clean_pass", pass, 1'b1);
    run_steps(10, 12, 16'h0000, 16'h0000);
    chk("clean_hold_done", done, 1'b1);
    chk("clean_hold_sample", sample_cnt, 16'd8);

    // Start from DONE clears counters; mismatches on samples 3 and 6
    run_start();
    chk("restart_sample", sample_cnt, 16'd0);
    chk("restart_done", done, 1'b0);
    chk("restart_busy", busy, 1'b1);
    run_steps(1, 4, 16'h0090, 16'h0000);
    chk("err2_mid_err", err_cnt, 16'd1);
    chk("err2_mid_sample", sample_cnt, 16'd3);
    run_steps(5, 9, 16'h0090, 16'h0000);
    chk("err2_err", err_cnt, 16'd2);
    chk("err2_sample", sample_cnt, 16'd8);
    chk("err2_done", done, 1'b1);
    chk("err2_pass", pass, 1'b0);
`ifdef DFF_CHK_FIRST_ERR_EN
    chk("err2_fe_vld", fe_vld, 1'b1);
    chk("err2_fe_idx", fe_idx, 16'd3);
    chk("err2_fe_exp", fe_exp, 1'b1);
`endif

    // dut_rst=1, d_obs=1 for three checked samples, q_obs=0
    run_start();
    run_steps(1, 9, 16'h0000, 16'h000E);
    chk("dutrst_ok_err", err_cnt, 16'd0);
    chk("dutrst_ok_pass", pass, 1'b1);
    // same, but q_obs=1 on those samples
    run_start();
    run_steps(1, 9, 16'h001C, 16'h000E);
    chk("dutrst_bad_err", err_cnt, 16'd3);
    chk("dutrst_bad_pass", pass, 1'b0);
    chk("dutrst_bad_sample", sample_cnt, 16'd8);
`ifdef DFF_CHK_FIRST_ERR_EN
    chk("dutrst_fe_idx", fe_idx, 16'd1);
    chk("dutrst_fe_exp", fe_exp, 1'b0);
`endif

    // Reset during CHECK at sample 4 aborts the run
    run_start();
    run_steps(1, 4, 16'h0004, 16'h0000);
    chk("abort_pre_sample", sample_cnt, 16'd3);
    chk("abort_pre_err", err_cnt, 16'd1);
    rst = 1'b0;
    step(pat[5], 1'b0, 1'b0, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sample", sample_cnt, 16'd0);
    chk("abort_err", err_cnt, 16'd0);
    rst = 1'b1;
    run_steps(6, 9, 16'h0000, 16'h0000);
    chk("abort_no_done", done, 1'b0);
    chk("abort_idle_busy", busy, 1'b0);
    run_start();
    run_steps(1, 9, 16'h0000, 16'h0000);
    chk("after_abort_done", done, 1'b1);
    chk("after_abort_sample", sample_cnt, 16'd8);
    chk("after_abort_pass", pass, 1'b1);

    // Start during CHECK is ignored
    run_start();
    run_steps(1, 4, 16'h0000, 16'h0000);
    step(pat[5], 1'b0, 1'b0, 1'b1);
    chk("start_in_check_sample", sample_cnt, 16'd4);
    chk("start_in_check_busy", busy, 1'b1);
    run_steps(6, 9, 16'h0000, 16'h0000);
    chk("start_in_check_done", done, 1'b1);
    chk("start_in_check_final", sample_cnt, 16'd8);

    // All samples mismatched: small instance saturates err_cnt at 7
    run_start();
    run_steps(1, 8, 16'hFFFE, 16'h0000);
    chk("sat_small_done", s_done, 1'b1);
    chk("sat_small_err", s_err_cnt, 3'd7);
    chk("sat_small_sample", s_sample_cnt, 3'd7);
    chk("sat_small_pass", s_pass, 1'b0);
    chk("sat_main_err_k8", err_cnt, 16'd7);
    chk("sat_main_done_k8", done, 1'b0);
    run_steps(9, 11, 16'hFFFE, 16'h0000);
    chk("sat_small_err_hold", s_err_cnt, 3'd7);
    chk("sat_small_done_hold", s_done, 1'b1);
    chk("sat_main_err", err_cnt, 16'd8);
    chk("sat_main_pass", pass, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
